// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle CPU main controller: ALU op codes,
// opcodes, mux selects, state codes and the packed control vector.
package mc_control_pkg;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_I_EXEC    = 4'd10,
    ST_I_WB      = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational state + mem_ready to control-vector decoder. All write and
// request strobes are held low while reset is asserted.
module mc_control_decode
  import mc_control_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic [5:0] opcode_i,
  input  logic       rst_n,
  output ctrl_t      ctrl_o
);

  ctrl_t raw;

  always_comb begin
    raw = '0;
    case (state_i)
      ST_FETCH: begin
        raw.mem_read  = 1'b1;
        raw.alu_src_b = SRCB_FOUR;
        raw.aluop     = ALUOP_ADD;
        raw.pc_source = PCSRC_ALU;
        raw.ir_write  = mem_ready_i;
        raw.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively while the opcode is decoded.
        raw.alu_src_b  = SRCB_IMM_SH;
        raw.aluop      = ALUOP_ADD;
        raw.illegal_op = !is_legal_op(opcode_i);
      end
      ST_MEM_ADDR: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        raw.mem_read = 1'b1;
        raw.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        raw.reg_write  = 1'b1;
        raw.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        raw.mem_write = 1'b1;
        raw.iord      = 1'b1;
      end
      ST_R_EXEC: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_B;
        raw.aluop     = ALUOP_FUNC;
      end
      ST_R_WB: begin
        raw.reg_write = 1'b1;
        raw.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        raw.alu_src_a     = 1'b1;
        raw.alu_src_b     = SRCB_B;
        raw.aluop         = ALUOP_SUB;
        raw.pc_write_cond = 1'b1;
        raw.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        raw.pc_write  = 1'b1;
        raw.pc_source = PCSRC_JUMP;
      end
      ST_I_EXEC: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_IMM;
      end
      ST_I_WB: begin
        raw.reg_write = 1'b1;
      end
      default: raw = '0;
    endcase
  end

  always_comb begin
    ctrl_o = raw;
    if (!rst_n) begin
      ctrl_o.pc_write      = 1'b0;
      ctrl_o.pc_write_cond = 1'b0;
      ctrl_o.mem_read      = 1'b0;
      ctrl_o.mem_write     = 1'b0;
      ctrl_o.ir_write      = 1'b0;
      ctrl_o.reg_write     = 1'b0;
      ctrl_o.illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Main control FSM of the multi-cycle CPU: state register and next-state
// logic; control outputs come from mc_control_decode.
module mc_control
  import mc_control_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] aluop_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_e'(RESET_STATE);
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:     state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_I_EXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode_i == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: state_d = mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_I_EXEC:    state_d = ST_I_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  mc_control_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_i),
    .opcode_i    (opcode_i),
    .rst_n       (rst_n),
    .ctrl_o      (ctrl)
  );

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign iord_o          = ctrl.iord;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign aluop_o         = ctrl.aluop;
  assign pc_source_o     = ctrl.pc_source;
  assign illegal_op_o    = ctrl.illegal_op;
  assign state_o         = state_q;

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Main control FSM for the multi-cycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and muxes, and produces the 2-bit aluop that the ALU control decoder expands into the 3-bit ALU operation.
- Memory steps use a mem_ready handshake, so variable-latency memory stalls the FSM.

Parameters:
- RESET_STATE, 4'd0, state code entered on reset (FETCH). Must not be changed in normal use; exposed only for bring-up.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination select: 0=rt, 1=rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- aluop  out  2  00=add, 01=sub, 10=use func field
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state, for debug and bench

Behaviour:
- Registered state. Outputs are combinational from state; only the mem_ready gating is Mealy.
- Reset: asynchronous, takes effect immediately; state=FETCH.
  - While rst_n=0, every write/request output (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op) is forced 0.
  - Mux selects take their FETCH values.
  - Reset mid-instruction abandons it; no partial writeback.
- States and transitions:
  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00.
    - ir_write=pc_write=mem_ready.
    - Stay while mem_ready=0; ->DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=0, alu_src_b=11, aluop=00 (branch target precompute).
    - opcode 100011(lw)/101011(sw) ->MEM_ADDR; 000000(R) ->R_EXEC; 000100(beq) ->BRANCH; 000010(j) ->JUMP; 001000(addi) ->I_EXEC.
    - Any other opcode: illegal_op=1 ->FETCH.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, aluop=00. lw ->MEM_READ, sw ->MEM_WRITE.
  - MEM_READ(3): mem_read=1, iord=1. Hold until mem_ready=1, then ->MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0 ->FETCH.
  - MEM_WRITE(5): mem_write=1, iord=1. Hold until mem_ready=1, then ->FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, aluop=10 ->R_WB.
  - R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0 ->FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01 ->FETCH.
  - JUMP(9): pc_write=1, pc_source=10 ->FETCH.
  - I_EXEC(10): alu_src_a=1, alu_src_b=10, aluop=00 ->I_WB.
  - I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0 ->FETCH.
  - Codes 12-15 unreachable; if entered, ->FETCH with all enables 0.
- Latency in cycles with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each cycle of mem_ready=0 adds one.
- The memory request is held stable for the whole stall. The request deasserts the cycle after the mem_ready=1 cycle.
- opcode is sampled only in DECODE and in the MEM_ADDR decision. The IR is not rewritten until the next FETCH.
- Any output not listed for a state is 0.

Decomposition:
- Shared header ctrl.vh, alongside the ALU header, holds:
  - ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNC=2'b10
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - the twelve state codes
- One sub-module is natural: mc_control_decode, a combinational state+mem_ready to control-vector decoder.
- mc_control keeps only the state register and next-state logic.

Test Plan:
- Reset: hold rst_n=0 with mem_ready=1 -> state=0; pc_write=ir_write=reg_write=0 throughout. Release -> first rising edge moves to DECODE.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0. aluop=10 in state 6; reg_write=1 and reg_dst=1 in state 7 only.
- lw with a 2-cycle wait in MEM_READ: opcode=100011, mem_ready low for 2 cycles in state 3 -> mem_read=1, iord=1 held 3 cycles. Then MEM_WB with mem_to_reg=1, reg_write=1; total 7 cycles.
- sw, fetch stall 1 cycle: opcode=101011 -> ir_write/pc_write low in the stall cycle, high in the ready cycle. mem_write=1 in state 5 only.
- beq then j: beq -> state 8 with aluop=01, pc_write_cond=1, pc_source=01. j -> state 9 with pc_write=1, pc_source=10.
- Illegal opcode 111111: illegal_op pulses exactly one cycle in DECODE, then FETCH. Asserting rst_n=0 mid-MEM_READ -> immediate FETCH with mem_read=0.
